// File: rtl/spi_mailbox_pkg.sv
// Shared constants, command field positions and FSM encoding for the SPI mailbox slave.
package spi_mailbox_pkg;

  localparam int unsigned NUM_REGS   = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned FLAT_W     = NUM_REGS * 8;
  localparam logic [7:0]  SYNC_MARK  = 8'hA5;

  localparam int unsigned CMD_W_BIT  = 7;
  localparam int unsigned CMD_IDX_HI = 2;
  localparam int unsigned CMD_IDX_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  function automatic logic [7:0] flat_byte(input logic [FLAT_W-1:0] flat,
                                           input logic [IDX_W-1:0]  idx);
    return flat[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/spi_mailbox_slave_if.sv
// SPI pins plus the Z80 mailbox buses; slave modport is the FPGA side, master the driving side.
interface spi_mailbox_slave_if;
  import spi_mailbox_pkg::*;

  logic              spi_sck;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic [FLAT_W-1:0] z80_to_spi_flat;
  logic [FLAT_W-1:0] spi_to_z80_flat;
  logic [NUM_REGS-1:0] spi_wr_stb;

  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi, z80_to_spi_flat,
    output spi_miso, spi_to_z80_flat, spi_wr_stb
  );

  modport master (
    output spi_sck, spi_cs_n, spi_mosi, z80_to_spi_flat,
    input  spi_miso, spi_to_z80_flat, spi_wr_stb
  );

endinterface

// File: rtl/spi_mailbox_slave_sync_edge.sv
// 2-FF synchronizer with one-cycle rise/fall pulses; pulses appear 2 clk after the pin edge.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {3{RST_VAL}};
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  // sync_q[1] is the synchronized level, sync_q[2] its previous value
  assign rise_o =  sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/spi_mailbox_slave.sv
// SPI mode-0 slave bridging a byte-wide command/data protocol onto eight Z80 mailbox registers.
// Pin-to-action latency is 3 clk; SPI has no flow control, so clk must run at least 8x SCK.
module spi_mailbox_slave
  import spi_mailbox_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  spi_mailbox_slave_if.slave bus
);

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic [1:0] mosi_q;

  sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .d_i(bus.spi_sck), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .d_i(bus.spi_cs_n), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_q <= 2'b00;
    end else begin
      mosi_q <= {mosi_q[0], bus.spi_mosi};
    end
  end

  state_e              state_q;
  logic [2:0]          bit_cnt_q;
  logic [7:0]          rx_q;
  logic [7:0]          tx_q;
  logic [IDX_W-1:0]    idx_q;
  logic                wr_q;
  logic [FLAT_W-1:0]   regs_q;
  logic [NUM_REGS-1:0] stb_q;

  logic [7:0]       rx_d;
  logic [IDX_W-1:0] cmd_idx_d;
  logic [IDX_W-1:0] idx_d;

  assign rx_d      = {rx_q[6:0], mosi_q[1]};
  assign cmd_idx_d = rx_d[CMD_IDX_HI:CMD_IDX_LO];
  assign idx_d     = idx_q + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      rx_q      <= 8'h00;
      tx_q      <= 8'h00;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      regs_q    <= '0;
      stb_q     <= '0;
    end else begin
      stb_q <= '0;
      if (cs_fall) begin
        state_q   <= ST_CMD;
        bit_cnt_q <= 3'd0;
        tx_q      <= SYNC_MARK;
      end else if (state_q != ST_IDLE) begin
        if (sck_rise) begin
          rx_q      <= rx_d;
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (state_q == ST_CMD) begin
              wr_q    <= rx_d[CMD_W_BIT];
              idx_q   <= cmd_idx_d;
              tx_q    <= flat_byte(bus.z80_to_spi_flat, cmd_idx_d);
              state_q <= ST_DATA;
            end else begin
              if (wr_q) begin
                regs_q[{idx_q, 3'b000} +: 8] <= rx_d;
                stb_q[idx_q]                 <= 1'b1;
              end
              idx_q <= idx_d;
              tx_q  <= flat_byte(bus.z80_to_spi_flat, idx_d);
            end
          end
        // The falling edge right after a byte's last rise must not shift out the freshly loaded MSB
        end else if (sck_fall && bit_cnt_q != 3'd0) begin
          tx_q <= {tx_q[6:0], 1'b0};
        end
        // A completing byte in this same cycle still commits above before we drop to IDLE
        if (cs_rise) begin
          state_q   <= ST_IDLE;
          bit_cnt_q <= 3'd0;
          tx_q      <= 8'h00;
        end
      end
    end
  end

  assign bus.spi_miso        = (state_q != ST_IDLE) && tx_q[7];
  assign bus.spi_to_z80_flat = regs_q;
  assign bus.spi_wr_stb      = stb_q;

endmodule

// File: tb/tb_spi_mailbox_slave.sv
// Directed bench for spi_mailbox_slave: drives SPI transactions and checks MISO, registers and strobes.
module tb_spi_mailbox_slave;

  localparam int HALF = 8;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  spi_mailbox_slave_if bus();

  spi_mailbox_slave dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] exp_flat;
  time         last_rise_t;
  logic [7:0]  stb_log[$];
  logic [63:0] flat_log[$];
  time         t_log[$];

  always @(negedge clk) begin
    if (bus.spi_wr_stb !== 8'h00) begin
      stb_log.push_back(bus.spi_wr_stb);
      flat_log.push_back(bus.spi_to_z80_flat);
      t_log.push_back($time);
    end
  end

  task automatic clear_log();
    stb_log.delete();
    flat_log.delete();
    t_log.delete();
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // Sends the top nbits of tx MSB first; MISO is sampled just before each rising edge
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit cs_with_last,
                          output logic [7:0] rx);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.spi_mosi = tx[i];
      repeat (HALF) @(negedge clk);
      r[i] = bus.spi_miso;
      bus.spi_sck = 1'b1;
      last_rise_t = $time;
      if (i == 8 - nbits && cs_with_last) bus.spi_cs_n = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.spi_sck = 1'b0;
    end
    rx = r;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.spi_to_z80_flat !== 64'h0) begin
      errors++; $display("FAIL reset_flat: got %h expected %h", bus.spi_to_z80_flat, 64'h0);
    end
    checks++;
    if (bus.spi_wr_stb !== 8'h00) begin
      errors++; $display("FAIL reset_stb: got %b expected %b", bus.spi_wr_stb, 8'h00);
    end
    checks++;
    if (bus.spi_miso !== 1'b0) begin
      errors++; $display("FAIL reset_miso: got %b expected 0", bus.spi_miso);
    end
  endtask

  task automatic test_single_write();
    logic [7:0] rx0, rx1;
    clear_log();
    cs_low();
    spi_bits(8'h83, 8, 1'b0, rx0);
    spi_bits(8'h5A, 8, 1'b0, rx1);
    cs_high();
    exp_flat[31:24] = 8'h5A;
    checks++;
    if (rx0 !== 8'hA5) begin
      errors++; $display("FAIL wr_sync_mark: got %h expected %h", rx0, 8'hA5);
    end
    checks++;
    if (stb_log.size() !== 1) begin
      errors++; $display("FAIL wr_stb_count: got %0d expected 1", stb_log.size());
    end else begin
      checks++;
      if (stb_log[0] !== 8'b0000_1000) begin
        errors++; $display("FAIL wr_stb_bit: got %b expected %b", stb_log[0], 8'b0000_1000);
      end
      checks++;
      if (flat_log[0][31:24] !== 8'h5A) begin
        errors++; $display("FAIL wr_data_with_stb: got %h expected %h", flat_log[0][31:24], 8'h5A);
      end
      checks++;
      if (t_log[0] - last_rise_t !== 30) begin
        errors++; $display("FAIL wr_latency: got %0t expected 30", t_log[0] - last_rise_t);
      end
    end
    checks++;
    if (bus.spi_to_z80_flat !== exp_flat) begin
      errors++; $display("FAIL wr_regs: got %h expected %h", bus.spi_to_z80_flat, exp_flat);
    end
    checks++;
    if (bus.spi_miso !== 1'b0) begin
      errors++; $display("FAIL idle_miso: got %b expected 0", bus.spi_miso);
    end
  endtask

  task automatic test_single_read();
    logic [7:0] rx0, rx1;
    clear_log();
    bus.z80_to_spi_flat = 64'hF0E1_3700_C3B4_A596;
    cs_low();
    spi_bits(8'h05, 8, 1'b0, rx0);
    spi_bits(8'h00, 8, 1'b0, rx1);
    cs_high();
    checks++;
    if (rx0 !== 8'hA5) begin
      errors++; $display("FAIL rd_sync_mark: got %h expected %h", rx0, 8'hA5);
    end
    checks++;
    if (rx1 !== 8'h37) begin
      errors++; $display("FAIL rd_data: got %h expected %h", rx1, 8'h37);
    end
    checks++;
    if (stb_log.size() !== 0) begin
      errors++; $display("FAIL rd_no_stb: got %0d strobes expected 0", stb_log.size());
    end
    checks++;
    if (bus.spi_to_z80_flat !== exp_flat) begin
      errors++; $display("FAIL rd_regs: got %h expected %h", bus.spi_to_z80_flat, exp_flat);
    end
  endtask

  task automatic test_burst_write();
    logic [7:0] rx;
    logic [7:0] data[3];
    logic [7:0] exp_stb[3];
    int         exp_pos[3];
    data    = '{8'h11, 8'h22, 8'h33};
    exp_stb = '{8'h40, 8'h80, 8'h01};
    exp_pos = '{48, 56, 0};
    clear_log();
    cs_low();
    spi_bits(8'h86, 8, 1'b0, rx);
    for (int i = 0; i < 3; i++) spi_bits(data[i], 8, 1'b0, rx);
    cs_high();
    exp_flat[55:48] = 8'h11;
    exp_flat[63:56] = 8'h22;
    exp_flat[7:0]   = 8'h33;
    checks++;
    if (stb_log.size() !== 3) begin
      errors++; $display("FAIL burst_wr_stb_count: got %0d expected 3", stb_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (stb_log[i] !== exp_stb[i] || flat_log[i][exp_pos[i] +: 8] !== data[i]) begin
          errors++;
          $display("FAIL burst_wr_%0d: got stb %b data %h expected stb %b data %h", i,
                   stb_log[i], flat_log[i][exp_pos[i] +: 8], exp_stb[i], data[i]);
        end
      end
    end
    checks++;
    if (bus.spi_to_z80_flat !== exp_flat) begin
      errors++; $display("FAIL burst_wr_regs: got %h expected %h", bus.spi_to_z80_flat, exp_flat);
    end
  endtask

  task automatic test_burst_read();
    logic [7:0] rx0, rx1, rx2;
    clear_log();
    bus.z80_to_spi_flat = 64'h8877_6655_4433_2211;
    cs_low();
    spi_bits(8'h07, 8, 1'b0, rx0);
    // Byte 7 was already loaded at the end of the command byte
    bus.z80_to_spi_flat[63:56] = 8'hEE;
    spi_bits(8'h00, 8, 1'b0, rx1);
    spi_bits(8'h00, 8, 1'b0, rx2);
    cs_high();
    checks++;
    if (rx0 !== 8'hA5) begin
      errors++; $display("FAIL burst_rd_sync: got %h expected %h", rx0, 8'hA5);
    end
    checks++;
    if (rx1 !== 8'h88) begin
      errors++; $display("FAIL burst_rd_reg7: got %h expected %h", rx1, 8'h88);
    end
    checks++;
    if (rx2 !== 8'h11) begin
      errors++; $display("FAIL burst_rd_wrap_reg0: got %h expected %h", rx2, 8'h11);
    end
    checks++;
    if (stb_log.size() !== 0) begin
      errors++; $display("FAIL burst_rd_no_stb: got %0d strobes expected 0", stb_log.size());
    end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    clear_log();
    cs_low();
    spi_bits(8'h82, 8, 1'b0, rx);
    spi_bits(8'hA0, 4, 1'b0, rx);
    cs_high();
    checks++;
    if (stb_log.size() !== 0) begin
      errors++; $display("FAIL abort_no_stb: got %0d strobes expected 0", stb_log.size());
    end
    checks++;
    if (bus.spi_to_z80_flat !== exp_flat) begin
      errors++; $display("FAIL abort_regs: got %h expected %h", bus.spi_to_z80_flat, exp_flat);
    end
    cs_low();
    spi_bits(8'h82, 8, 1'b0, rx);
    spi_bits(8'hC3, 8, 1'b0, rx);
    cs_high();
    exp_flat[23:16] = 8'hC3;
    checks++;
    if (stb_log.size() !== 1 || stb_log[0] !== 8'h04) begin
      errors++; $display("FAIL abort_rewrite_stb: got %0d strobes expected one 00000100", stb_log.size());
    end
    checks++;
    if (bus.spi_to_z80_flat !== exp_flat) begin
      errors++; $display("FAIL abort_rewrite_regs: got %h expected %h", bus.spi_to_z80_flat, exp_flat);
    end
  endtask

  task automatic test_cs_with_last_edge();
    logic [7:0] rx;
    clear_log();
    cs_low();
    spi_bits(8'h84, 8, 1'b0, rx);
    spi_bits(8'h9C, 8, 1'b1, rx);
    repeat (HALF) @(negedge clk);
    exp_flat[39:32] = 8'h9C;
    checks++;
    if (stb_log.size() !== 1 || stb_log[0] !== 8'h10) begin
      errors++; $display("FAIL cs_last_stb: got %0d strobes expected one 00010000", stb_log.size());
    end
    checks++;
    if (bus.spi_to_z80_flat !== exp_flat) begin
      errors++; $display("FAIL cs_last_regs: got %h expected %h", bus.spi_to_z80_flat, exp_flat);
    end
    checks++;
    if (bus.spi_miso !== 1'b0) begin
      errors++; $display("FAIL cs_last_idle_miso: got %b expected 0", bus.spi_miso);
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] rx;
    clear_log();
    cs_low();
    spi_bits(8'h81, 8, 1'b0, rx);
    spi_bits(8'hFF, 4, 1'b0, rx);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_flat = 64'h0;
    test_reset();
    bus.spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (stb_log.size() !== 0) begin
      errors++; $display("FAIL rst_no_stb: got %0d strobes expected 0", stb_log.size());
    end
    checks++;
    if (bus.spi_to_z80_flat !== exp_flat) begin
      errors++; $display("FAIL rst_regs_after: got %h expected %h", bus.spi_to_z80_flat, exp_flat);
    end
  endtask

  initial begin
    rst                 = 1'b1;
    bus.spi_cs_n        = 1'b1;
    bus.spi_sck         = 1'b0;
    bus.spi_mosi        = 1'b0;
    bus.z80_to_spi_flat = 64'h0;
    exp_flat            = 64'h0;
    last_rise_t         = 0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    test_single_write();
    test_single_read();
    test_burst_write();
    test_burst_read();
    test_abort();
    test_cs_with_last_edge();
    test_reset_mid_byte();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
